ultrasonic_echo_timer: RTL and testbench

//  Ranging controller downstream of the free-running 40 kHz carrier generator.
//  On a start request it gates a burst of whole carrier periods to the transducer

---
 rtl/ultrasonic_echo_timer_pkg.sv | 22 ++
 rtl/ultrasonic_echo_timer_if.sv | 32 +++
 rtl/ultrasonic_echo_timer_sync_2ff.sv | 21 ++
 rtl/ultrasonic_echo_timer.sv | 116 +++++++++++
 tb/tb_ultrasonic_echo_timer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ultrasonic_echo_timer_pkg.sv
// Shared types and default timing for the ultrasonic ranging controller.
package ultrasonic_echo_timer_pkg;

  // Measurement sequence: wait for request, align to carrier, transmit,
  // mask ringing, wait for echo, present result.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_BURST  = 3'd2,
    ST_BLANK  = 3'd3,
    ST_LISTEN = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Defaults shared with the carrier generator (50 MHz clk, 40 kHz carrier).
  localparam int unsigned CARRIER_PERIOD   = 1250;
  localparam int unsigned DEF_BURST_CYCLES = 8;
  localparam int unsigned DEF_BLANK_CLKS   = 50_000;
  localparam int unsigned DEF_TIMEOUT_CLKS = 1_500_000;
  localparam int unsigned DEF_CNT_W        = 24;

endpackage

// File: rtl/ultrasonic_echo_timer_if.sv
// Bundle of the ranging controller's request, carrier, echo and result signals.
//
// Handshake: start is a one-cycle request that is only accepted while busy is
// low; a request seen while busy is high is dropped, never queued. tof_valid
// is a one-cycle strobe with no back-pressure; tof_clks and timeout are
// updated in that same cycle and then held until the next strobe.
interface ultrasonic_echo_timer_if #(
  parameter int unsigned CNT_W = 24
);
  import ultrasonic_echo_timer_pkg::*;

  logic             start;
  logic             pulse_in;
  logic             echo_in;
  logic             tx_out;
  logic             busy;
  logic             tof_valid;
  logic [CNT_W-1:0] tof_clks;
  logic             timeout;
  state_t           dbg_state;

  modport master (
    output start, pulse_in, echo_in,
    input  tx_out, busy, tof_valid, tof_clks, timeout, dbg_state
  );

  modport slave (
    input  start, pulse_in, echo_in,
    output tx_out, busy, tof_valid, tof_clks, timeout, dbg_state
  );

endinterface

// File: rtl/ultrasonic_echo_timer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Deliberately has no reset: it keeps tracking the input through reset so the
// edge history is already valid on the first cycle after reset releases.
module ultrasonic_echo_timer_sync_2ff (
  input  logic i_clk,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge i_clk) begin
    r_s1 <= i_d;
    r_s2 <= r_s1;
  end

  assign o_q = r_s2;

endmodule

// File: rtl/ultrasonic_echo_timer.sv
// Ultrasonic ranging controller: gates a burst of whole carrier periods to the
// transducer, blanks the receiver, then timestamps the first echo rising edge
// (or reports a timeout) in clk cycles measured from the first burst cycle.
module ultrasonic_echo_timer
  import ultrasonic_echo_timer_pkg::*;
#(
  parameter int unsigned BURST_CYCLES = DEF_BURST_CYCLES,
  parameter int unsigned BLANK_CLKS   = DEF_BLANK_CLKS,
  parameter int unsigned TIMEOUT_CLKS = DEF_TIMEOUT_CLKS,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  ultrasonic_echo_timer_if.slave bus
);

  localparam int unsigned BURST_W = $clog2(BURST_CYCLES + 1);

  localparam logic [CNT_W-1:0]   BLANK_LAST   = CNT_W'(BLANK_CLKS - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_VAL  = CNT_W'(TIMEOUT_CLKS);
  localparam logic [BURST_W-1:0] BURST_LAST   = BURST_W'(BURST_CYCLES - 1);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_tof_cnt;
  logic [CNT_W-1:0]   r_tof_clks;
  logic               r_timeout;
  logic [BURST_W-1:0] r_burst_cnt;
  logic               r_echo_prev;
  logic               r_pulse_prev;
  logic               w_echo_sync;
  logic               w_echo_edge;
  logic               w_fall;

  ultrasonic_echo_timer_sync_2ff u_echo_sync (
    .i_clk (clk),
    .i_d   (bus.echo_in),
    .o_q   (w_echo_sync)
  );

  // Edge history for echo and carrier; runs regardless of reset or state.
  always_ff @(posedge clk) begin
    r_echo_prev  <= w_echo_sync;
    r_pulse_prev <= bus.pulse_in;
  end

  assign w_echo_edge = w_echo_sync & ~r_echo_prev;
  assign w_fall      = r_pulse_prev & ~bus.pulse_in;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; an echo edge beats the timeout in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.start) w_next = ST_ARM;
      // Open the gate only while the carrier is low so no partial pulse goes out.
      ST_ARM:    if (!bus.pulse_in) w_next = ST_BURST;
      ST_BURST:  if (w_fall && (r_burst_cnt == BURST_LAST)) w_next = ST_BLANK;
      ST_BLANK:  if (r_tof_cnt >= BLANK_LAST) w_next = ST_LISTEN;
      ST_LISTEN: if (w_echo_edge || (r_tof_cnt == TIMEOUT_LAST)) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Time-of-flight and burst counters; tof reads 0 on the first BURST cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tof_cnt   <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        ST_ARM: begin
          r_tof_cnt   <= '0;
          r_burst_cnt <= '0;
        end
        ST_BURST: begin
          r_tof_cnt <= r_tof_cnt + CNT_W'(1);
          if (w_fall) r_burst_cnt <= r_burst_cnt + BURST_W'(1);
        end
        ST_BLANK, ST_LISTEN: r_tof_cnt <= r_tof_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Capture the result on LISTEN exit; it is held until the next capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tof_clks <= '0;
      r_timeout  <= 1'b0;
    end else if (r_state == ST_LISTEN) begin
      if (w_echo_edge) begin
        r_tof_clks <= r_tof_cnt;
        r_timeout  <= 1'b0;
      end else if (r_tof_cnt == TIMEOUT_LAST) begin
        r_tof_clks <= TIMEOUT_VAL;
        r_timeout  <= 1'b1;
      end
    end
  end

  assign bus.tx_out    = bus.pulse_in & (r_state == ST_BURST);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.tof_valid = (r_state == ST_DONE);
  assign bus.tof_clks  = r_tof_clks;
  assign bus.timeout   = r_timeout;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_ultrasonic_echo_timer.sv
// Bench for ultrasonic_echo_timer: a cycle-indexed timeline model derives the
// burst window, blanking end and result from the carrier and echo waveforms.
`timescale 1ns/1ps
module tb_ultrasonic_echo_timer;
  import ultrasonic_echo_timer_pkg::*;

  localparam int BURST_N = 2;
  localparam int BLANK_N = 100;
  localparam int TMO_N   = 1000;
  localparam int CW      = 24;
  localparam int NCYC    = 60000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ultrasonic_echo_timer_if #(.CNT_W(CW)) bus ();

  ultrasonic_echo_timer #(
    .BURST_CYCLES (BURST_N),
    .BLANK_CLKS   (BLANK_N),
    .TIMEOUT_CLKS (TMO_N),
    .CNT_W        (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit echo_wave [NCYC];

  // Model of the current measurement, as absolute cycle numbers.
  int m_s = -10, m_b0 = -10, m_tx_end = -10, m_end = -10, m_d = -10;
  int m_tof = 0, m_to = 0, rst_at = -10;
  int h_tof = 0, h_to = 0;
  int tx_rises = 0, first_rise = -1, n_valid = 0;
  int last_valid_tof = -1, last_valid_to = -1;
  logic prev_tx = 1'b0;
  bit e_busy, e_tx, e_valid;
  logic [CW-1:0] exp_q[$];

  function automatic bit pulse_f(input int k);
    return k[2];
  endfunction

  function automatic bit edge_f(input int k);
    if (k < 3 || k >= NCYC) return 1'b0;
    return echo_wave[k-2] && !echo_wave[k-3];
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 5000) begin
      tick();
      guard++;
    end
    if (cyc < t) check("wait_bound", cyc, t);
  endtask

  // Carrier and echo waveforms are functions of the cycle number.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    bus.pulse_in = pulse_f(cyc);
    bus.echo_in  = (cyc < NCYC) ? echo_wave[cyc] : 1'b0;
  end

  // One measurement: echo_n < 0 means no echo; echo rises at tof count echo_n.
  task automatic run_meas(input int echo_n, input int hold, input bit carrier_high,
                          input bit st_burst, input bit st_done, input bit do_rst);
    int s, a, b0, f, lst, d, tof, to, nf, k;
    wait_until(m_end + 1);
    repeat ($urandom_range(0, 5)) tick();
    if (carrier_high)
      while (!(pulse_f(cyc) && pulse_f(cyc + 1))) tick();
    s = cyc;
    a = s + 1;
    while (pulse_f(a)) a++;
    b0 = a + 1;
    nf = 0;
    k  = b0;
    while (nf < BURST_N) begin
      k++;
      if (pulse_f(k - 1) && !pulse_f(k)) nf++;
    end
    f   = k;
    lst = (f + 2 > b0 + BLANK_N) ? f + 2 : b0 + BLANK_N;
    for (int i = s + 1; i < b0 + TMO_N + 50 && i < NCYC; i++) echo_wave[i] = 1'b0;
    if (echo_n >= 0)
      for (int i = 0; i < hold && b0 + echo_n + i < NCYC; i++) echo_wave[b0 + echo_n + i] = 1'b1;
    d = b0 + TMO_N; tof = TMO_N; to = 1;
    for (int j = lst; j <= b0 + TMO_N - 1; j++)
      if (edge_f(j)) begin d = j + 1; tof = j - b0; to = 0; break; end
    m_s = s; m_b0 = b0; m_tx_end = f; m_end = d; m_d = d; m_tof = tof; m_to = to;
    tx_rises = 0; first_rise = -1;
    exp_q.push_back(CW'(tof));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    if (st_burst) begin
      wait_until(b0 + 2);
      bus.start = 1'b1; tick(); bus.start = 1'b0;
    end
    if (do_rst) begin
      wait_until(b0 + 5);
      rst = 1'b1;
      m_end = cyc; m_tx_end = (f < cyc) ? f : cyc; m_d = -10; rst_at = cyc;
      void'(exp_q.pop_back());
      tick();
      rst = 1'b0;
      return;
    end
    if (st_done) begin
      wait_until(d);
      bus.start = 1'b1; tick(); bus.start = 1'b0;
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (cyc >= 4) begin
      if (cyc == m_d) begin h_tof = m_tof; h_to = m_to; end
      if (cyc == rst_at + 1) begin h_tof = 0; h_to = 0; end
      e_busy  = (cyc >= m_s + 1) && (cyc <= m_end);
      e_tx    = (cyc >= m_b0) && (cyc <= m_tx_end) && pulse_f(cyc);
      e_valid = (cyc == m_d);
      check("busy", bus.busy, e_busy);
      check("tx_out", bus.tx_out, e_tx);
      check("tof_valid", bus.tof_valid, e_valid);
      check("tof_clks", bus.tof_clks, h_tof);
      check("timeout", bus.timeout, h_to);
      if (bus.tx_out && !prev_tx) begin
        tx_rises++;
        if (first_rise < 0) first_rise = cyc;
      end
      prev_tx = bus.tx_out;
      if (bus.tof_valid) begin
        n_valid++;
        last_valid_tof = int'(bus.tof_clks);
        last_valid_to  = int'(bus.timeout);
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else check("sb_tof", bus.tof_clks, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  int nv, rise_c;
  int bnd_n[4]    = '{98, 97, 997, 998};
  int bnd_tof[4]  = '{100, 1000, 999, 1000};
  int bnd_to[4]   = '{0, 1, 0, 1};

  initial begin
    bus.start = 1'b0; bus.pulse_in = 1'b0; bus.echo_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_tx", bus.tx_out, 0);
    check("rst_valid", bus.tof_valid, 0);
    check("rst_tof", bus.tof_clks, 0);
    check("rst_timeout", bus.timeout, 0);

    // Echo at tof 300 reports 302; exactly two carrier pulses transmitted.
    run_meas(300, 20, 0, 0, 0, 0);
    check("model_tof_300", m_tof, 302);
    wait_until(m_end + 1);
    check("dut_tof_300", last_valid_tof, 302);
    check("dut_to_300", last_valid_to, 0);
    check("burst_pulses", tx_rises, 2);
    check("busy_after", bus.busy, 0);

    // Echo during blanking and held: timeout at 1000.
    run_meas(50, 3000, 0, 0, 0, 0);
    check("model_tmo", m_tof, 1000);
    wait_until(m_end + 1);
    check("dut_tmo_tof", last_valid_tof, 1000);
    check("dut_tmo_flag", last_valid_to, 1);

    // Starts during BURST and DONE are dropped.
    nv = n_valid;
    run_meas($urandom_range(150, 800), 10, 0, 1, 1, 0);
    wait_until(m_end + 3);
    check("one_valid_per_start", n_valid - nv, 1);
    check("done_start_ignored", bus.busy, 0);

    // Reset in BURST, then a normal measurement.
    run_meas(200, 10, 0, 0, 0, 1);
    check("rstmid_tx", bus.tx_out, 0);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_tof", bus.tof_clks, 0);
    run_meas(400, 10, 0, 0, 0, 0);
    wait_until(m_end + 1);
    check("after_rst_tof", last_valid_tof, 402);

    // Start while carrier high: gate opens on the next carrier rise.
    run_meas(250, 10, 1, 0, 0, 0);
    rise_c = m_s + 1;
    while (!(pulse_f(rise_c) && !pulse_f(rise_c - 1))) rise_c++;
    wait_until(m_end + 1);
    check("first_tx_rise", first_rise, rise_c);
    check("arm_waited", m_b0 > m_s + 2, 1);

    // Blanking and timeout boundaries.
    for (int i = 0; i < 4; i++) begin
      run_meas(bnd_n[i], 5, 0, 0, 0, 0);
      check("bnd_model_tof", m_tof, bnd_tof[i]);
      wait_until(m_end + 1);
      check("bnd_dut_tof", last_valid_tof, bnd_tof[i]);
      check("bnd_dut_to", last_valid_to, bnd_to[i]);
    end

    // Randomized measurements.
    for (int i = 0; i < 8; i++) begin
      run_meas(int'($urandom_range(0, 1100)) - 1, $urandom_range(1, 40),
               1'($urandom_range(0, 1)), 0, 0, 0);
    end
    wait_until(m_end + 3);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #(10 * 90000);
    n_err++;
    $display("FAIL watchdog: cycle %0d reached, expected finish earlier", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
